alu_16bit: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_16bit_if.sv | 23 ++
 rtl/alu_comb.sv | 44 ++++
 rtl/alu_16bit.sv | 40 ++++
 tb/tb_alu_16bit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, data width and flag bundle for the 16-bit ALU.
package alu_pkg;
  localparam int DATA_W = 16;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NAND = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_GT   = 4'b1011;
  localparam logic [3:0] ALU_LT   = 4'b1100;
  localparam logic [3:0] ALU_SHR  = 4'b1101;
  localparam logic [3:0] ALU_SHL  = 4'b1110;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef struct packed {
    logic arith;
    logic lgc;
    logic cmp;
    logic shft;
  } flags_t;
endpackage

// File: rtl/alu_16bit_if.sv
// Operand/function/result bundle of the ALU; master drives operands, slave returns results.
interface alu_16bit_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        ALU_FUN;
  logic [DATA_W-1:0] ALU_OUT;
  logic              Arith_flag;
  logic              Logic_flag;
  logic              CMP_flag;
  logic              Shift_flag;

  modport master (
    output A, B, ALU_FUN,
    input  ALU_OUT, Arith_flag, Logic_flag, CMP_flag, Shift_flag
  );

  modport slave (
    input  A, B, ALU_FUN,
    output ALU_OUT, Arith_flag, Logic_flag, CMP_flag, Shift_flag
  );
endinterface

// File: rtl/alu_comb.sv
// Combinational result and class-flag decode, zero latency, no backpressure.
// Division is only built when ALU_DIV_EN is defined; otherwise opcode 0011 decodes as NOP.
module alu_comb
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_fun,
  output logic [DATA_W-1:0] o_result,
  output flags_t            o_flags
);

`ifdef ALU_DIV_EN
  logic [DATA_W-1:0] w_quot;
  // Divide-by-zero yields zero rather than the all-ones a raw divider would give.
  assign w_quot = (i_b == '0) ? '0 : (i_a / i_b);
`endif

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    case (i_fun)
      ALU_ADD:  begin o_result = i_a + i_b;            o_flags.arith = 1'b1; end
      ALU_SUB:  begin o_result = i_a - i_b;            o_flags.arith = 1'b1; end
      ALU_MUL:  begin o_result = i_a * i_b;            o_flags.arith = 1'b1; end
`ifdef ALU_DIV_EN
      ALU_DIV:  begin o_result = w_quot;               o_flags.arith = 1'b1; end
`endif
      ALU_AND:  begin o_result = i_a & i_b;            o_flags.lgc   = 1'b1; end
      ALU_OR:   begin o_result = i_a | i_b;            o_flags.lgc   = 1'b1; end
      ALU_NAND: begin o_result = ~(i_a & i_b);         o_flags.lgc   = 1'b1; end
      ALU_NOR:  begin o_result = ~(i_a | i_b);         o_flags.lgc   = 1'b1; end
      ALU_XOR:  begin o_result = i_a ^ i_b;            o_flags.lgc   = 1'b1; end
      ALU_XNOR: begin o_result = ~(i_a ^ i_b);         o_flags.lgc   = 1'b1; end
      ALU_EQ:   begin o_result = {15'd0, i_a == i_b};  o_flags.cmp   = 1'b1; end
      ALU_GT:   begin o_result = {15'd0, i_a > i_b};   o_flags.cmp   = 1'b1; end
      ALU_LT:   begin o_result = {15'd0, i_a < i_b};   o_flags.cmp   = 1'b1; end
      ALU_SHR:  begin o_result = {1'b0, i_a[15:1]};    o_flags.shft  = 1'b1; end
      ALU_SHL:  begin o_result = {i_a[14:0], 1'b0};    o_flags.shft  = 1'b1; end
      default:  begin o_result = '0;                   o_flags       = '0;   end
    endcase
  end

endmodule

// File: rtl/alu_16bit.sv
// Registered 16-bit ALU: 1-cycle latency, accepts a new op every cycle (no backpressure).
// Optional divider enabled by ALU_DIV_EN; async active-high rst clears result and flags.
module alu_16bit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_16bit_if.slave  bus
);

  logic [DATA_W-1:0] w_result;
  flags_t            w_flags;
  logic [DATA_W-1:0] r_out;
  flags_t            r_flags;

  alu_comb u_comb (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_fun    (bus.ALU_FUN),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      r_out   <= w_result;
      r_flags <= w_flags;
    end
  end

  assign bus.ALU_OUT    = r_out;
  assign bus.Arith_flag = r_flags.arith;
  assign bus.Logic_flag = r_flags.lgc;
  assign bus.CMP_flag   = r_flags.cmp;
  assign bus.Shift_flag = r_flags.shft;

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed vector table, reset/latency sequences, random ops vs model.
module tb_alu_16bit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_16bit_if bus();

  alu_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [15:0] exp_out;
    logic [3:0]  exp_flags;   // {arith, logic, cmp, shift}
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input logic [15:0] o, input logic [3:0] fl);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.exp_out = o; v.exp_flags = fl; v.name = name;
    vt.push_back(v);
  endtask

  function automatic logic [19:0] observed();
    return {bus.ALU_OUT, bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got out=%h flags=%b, expected out=%h flags=%b",
               name, act[19:4], act[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  // Reference model from the opcode table using plain unsigned arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int unsigned x, y, r;
    logic [3:0] fl;
    x = a; y = b; r = 0; fl = 4'b0000;
    case (f)
      4'd0:  r = (x + y) % 65536;
      4'd1:  r = (x + 65536 - y) % 65536;
      4'd2:  r = (x * y) % 65536;
`ifdef ALU_DIV_EN
      4'd3:  r = (y == 0) ? 0 : x / y;
`endif
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = 65535 - (x & y);
      4'd7:  r = 65535 - (x | y);
      4'd8:  r = x ^ y;
      4'd9:  r = 65535 - (x ^ y);
      4'd10: r = (x == y) ? 1 : 0;
      4'd11: r = (x > y) ? 1 : 0;
      4'd12: r = (x < y) ? 1 : 0;
      4'd13: r = x / 2;
      4'd14: r = (x * 2) % 65536;
      default: r = 0;
    endcase
`ifdef ALU_DIV_EN
    if (f <= 4'd3) fl = 4'b1000;
`else
    if (f <= 4'd2) fl = 4'b1000;
`endif
    else if (f >= 4'd4 && f <= 4'd9)  fl = 4'b0100;
    else if (f >= 4'd10 && f <= 4'd12) fl = 4'b0010;
    else if (f == 4'd13 || f == 4'd14) fl = 4'b0001;
    return {r[15:0], fl};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.ALU_FUN = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec("add",     16'd6, 16'd3, 4'b0000, 16'd9,     4'b1000);
    add_vec("sub",     16'd6, 16'd3, 4'b0001, 16'd3,     4'b1000);
    add_vec("mul",     16'd6, 16'd3, 4'b0010, 16'd18,    4'b1000);
`ifdef ALU_DIV_EN
    add_vec("div",     16'd6, 16'd3, 4'b0011, 16'd2,     4'b1000);
    add_vec("div0",    16'd5, 16'd0, 4'b0011, 16'd0,     4'b1000);
`else
    add_vec("div_off", 16'd6, 16'd3, 4'b0011, 16'd0,     4'b0000);
`endif
    add_vec("and",     16'd6, 16'd3, 4'b0100, 16'd2,     4'b0100);
    add_vec("or",      16'd6, 16'd3, 4'b0101, 16'd7,     4'b0100);
    add_vec("nand",    16'd6, 16'd3, 4'b0110, 16'hFFFD,  4'b0100);
    add_vec("nor",     16'd6, 16'd3, 4'b0111, 16'hFFF8,  4'b0100);
    add_vec("xor",     16'd6, 16'd3, 4'b1000, 16'd5,     4'b0100);
    add_vec("xnor",    16'd6, 16'd3, 4'b1001, 16'hFFFA,  4'b0100);
    add_vec("eq",      16'd6, 16'd3, 4'b1010, 16'd0,     4'b0010);
    add_vec("gt",      16'd6, 16'd3, 4'b1011, 16'd1,     4'b0010);
    add_vec("lt",      16'd6, 16'd3, 4'b1100, 16'd0,     4'b0010);
    add_vec("shr",     16'd6, 16'd3, 4'b1101, 16'd3,     4'b0001);
    add_vec("shl",     16'd6, 16'd3, 4'b1110, 16'd12,    4'b0001);
    add_vec("nop",     16'd6, 16'd3, 4'b1111, 16'd0,     4'b0000);
    add_vec("add_ovf", 16'hFFFF, 16'd1, 4'b0000, 16'd0,  4'b1000);
    add_vec("sub_wrap",16'd0, 16'd1, 4'b0001, 16'hFFFF,  4'b1000);
    add_vec("shl_msb", 16'h8000, 16'd0, 4'b1110, 16'd0,  4'b0001);
    add_vec("shr_b",   16'h8001, 16'hFFFF, 4'b1101, 16'h4000, 4'b0001);
    add_vec("eq_true", 16'hABCD, 16'hABCD, 4'b1010, 16'd1, 4'b0010);
    add_vec("lt_true", 16'd3, 16'd6, 4'b1100, 16'd1,     4'b0010);

    // Reset is seen before any clock edge, and held across edges.
    rst = 1'b1; bus.A = 16'd6; bus.B = 16'd3; bus.ALU_FUN = 4'b0000;
    #2;
    check("reset_async", observed(), 20'h0);
    @(posedge clk); #1;
    check("reset_held", observed(), 20'h0);

    // First edge after release captures the current inputs.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release", observed(), {16'd9, 4'b1000});

    foreach (vt[i]) begin
      drive(vt[i].a, vt[i].b, vt[i].f);
      check(vt[i].name, observed(), {vt[i].exp_out, vt[i].exp_flags});
    end

    // Latency: a mid-cycle input change is invisible until the next edge.
    drive(16'd6, 16'd3, 4'b0000);
    check("lat_first", observed(), {16'd9, 4'b1000});
    #1;
    bus.ALU_FUN = 4'b0001;
    bus.A = 16'd100;
    #2;
    check("lat_hold", observed(), {16'd9, 4'b1000});
    @(posedge clk); #1;
    check("lat_update", observed(), {16'd97, 4'b1000});

    // Mid-stream asynchronous reset clears without a clock edge.
    bus.A = 16'd6; bus.B = 16'd3; bus.ALU_FUN = 4'b1110;
    #1;
    rst = 1'b1;
    #1;
    check("reset_midstream", observed(), 20'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_resume", observed(), {16'd12, 4'b0001});

    // Back-to-back random operations against the model.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rf;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      rf = 4'($urandom_range(0, 15));
      drive(ra, rb, rf);
      check("random", observed(), model(ra, rb, rf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
